// File: rtl/rx_access_code_corr.sv
// rx_access_code_corr: sliding access-code correlator with search window, trailer and header timing.
// Build option: define ACCORR_PEAK_HOLD_EN to hold a threshold hit for one bit and keep the better peak.
module rx_access_code_corr #(
  parameter int SW_W  = 64,
  parameter int WIN_W = 10
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             p_1us,
  input  logic             rxbit,
  input  logic             corr_en,
  input  logic [SW_W-1:0]  regi_syncword,
  input  logic [6:0]       regi_corr_thresh,
  input  logic [WIN_W-1:0] regi_win_us,
  output logic [6:0]       corr_score,
  output logic             sync_det_p,
  output logic             rx_trailer_st_p,
  output logic             rx_header_st_p,
  output logic             search_timeout_p,
  output logic             corr_busy
);

  // state   | meaning
  // IDLE    | disarmed; arming clears shift register, fill and window count
  // SEARCH  | shifting bits, looking for a threshold hit inside the window
  // PEAK    | (peak-hold build) hit held for one bit to see if the next is better
  // TRAILER | sync found; counting the 4 trailer bits
  // DONE    | detection or timeout reported; waits for corr_en to drop
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
`ifdef ACCORR_PEAK_HOLD_EN
    PEAK    = 3'd2,
`endif
    TRAILER = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [6:0] FULL = 7'(SW_W);

  state_t            state;
  logic [SW_W-1:0]   shreg;
  logic [SW_W-1:0]   shreg_nx;
  logic [SW_W-1:0]   diff;
  logic [6:0]        mism;
  logic [6:0]        score_nx;
  logic [6:0]        fill;
  logic [WIN_W-1:0]  win_cnt;
  logic [1:0]        trl_cnt;
  logic              eval_q;
  logic              in_search;
  logic              shift_en;
  logic              fill_full;
  logic              thr_hit;
  logic              win_end;
`ifdef ACCORR_PEAK_HOLD_EN
  logic [6:0]        peak_score;
`endif

  assign shreg_nx = {rxbit, shreg[SW_W-1:1]};
  assign diff     = shreg_nx ^ regi_syncword;

  always_comb begin
    mism = '0;
    for (int i = 0; i < SW_W; i++) begin
      mism = mism + {6'd0, diff[i]};
    end
    score_nx = FULL - mism;
  end

`ifdef ACCORR_PEAK_HOLD_EN
  assign in_search = (state == SEARCH) || (state == PEAK);
`else
  assign in_search = (state == SEARCH);
`endif

  assign shift_en  = p_1us && corr_en && in_search;
  assign fill_full = (fill == FULL);
  // eval_q marks the clock where the freshly registered score is judged
  assign thr_hit   = eval_q && fill_full && (corr_score >= regi_corr_thresh);
  assign win_end   = eval_q && (win_cnt >= regi_win_us);

  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      state            <= IDLE;
      shreg            <= '0;
      fill             <= '0;
      win_cnt          <= '0;
      trl_cnt          <= '0;
      eval_q           <= 1'b0;
      corr_score       <= '0;
      sync_det_p       <= 1'b0;
      rx_trailer_st_p  <= 1'b0;
      rx_header_st_p   <= 1'b0;
      search_timeout_p <= 1'b0;
      corr_busy        <= 1'b0;
`ifdef ACCORR_PEAK_HOLD_EN
      peak_score       <= '0;
`endif
    end else begin
      sync_det_p       <= 1'b0;
      rx_trailer_st_p  <= 1'b0;
      rx_header_st_p   <= 1'b0;
      search_timeout_p <= 1'b0;
      eval_q           <= 1'b0;

      if (shift_en) begin
        shreg      <= shreg_nx;
        corr_score <= score_nx;
        eval_q     <= 1'b1;
        if (!fill_full) fill <= fill + 7'd1;
        if (win_cnt < regi_win_us) win_cnt <= win_cnt + WIN_W'(1);
      end

      if (!corr_en) begin
        state     <= IDLE;
        corr_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            shreg     <= '0;
            fill      <= '0;
            win_cnt   <= '0;
            trl_cnt   <= '0;
            state     <= SEARCH;
            corr_busy <= 1'b1;
          end
          SEARCH: begin
            if (thr_hit) begin
`ifdef ACCORR_PEAK_HOLD_EN
              peak_score <= corr_score;
              state      <= PEAK;
`else
              sync_det_p      <= 1'b1;
              rx_trailer_st_p <= 1'b1;
              trl_cnt         <= 2'd0;
              state           <= TRAILER;
`endif
            end else if (win_end) begin
              search_timeout_p <= 1'b1;
              state            <= DONE;
              corr_busy        <= 1'b0;
            end
          end
`ifdef ACCORR_PEAK_HOLD_EN
          PEAK: begin
            if (eval_q) begin
              sync_det_p      <= 1'b1;
              rx_trailer_st_p <= 1'b1;
              // keeping the held bit means one trailer bit is already behind us
              trl_cnt         <= (corr_score > peak_score) ? 2'd0 : 2'd1;
              state           <= TRAILER;
            end
          end
`endif
          TRAILER: begin
            if (p_1us) begin
              if (trl_cnt == 2'd3) begin
                rx_header_st_p <= 1'b1;
                state          <= DONE;
                corr_busy      <= 1'b0;
              end else begin
                trl_cnt <= trl_cnt + 2'd1;
              end
            end
          end
          DONE: begin
            corr_busy <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            corr_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
